dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage (CPU) and a debug/loader port (DBG).

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter_sat_counter.sv | 38 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership encoding,
// default fairness limits and a counter-width helper.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } own_e;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_LOCK_MAX     = 8;

  // Bits needed to hold 0..limit (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage, debug port and DataMemory signals that pass
// through the arbiter. slave = arbiter side, master = surrounding system.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  cpu_mem_read;
  logic                  cpu_mem_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  dbg_req;
  logic                  dbg_we;
  logic                  dbg_lock;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  dbg_gnt;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_rvalid;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear. at_limit reports that the
// count has reached LIMIT, or will reach it at this edge because of inc.
module sat_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = cnt_width(DEF_STARVE_LIMIT),
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; hold once saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != LIM))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q == LIM) | (inc & (cnt_q == LIM_M1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has priority, the debug
// port gets in when the CPU is idle or has starved it STARVE_LIMIT times,
// and may hold the memory for locked bursts of up to LOCK_MAX cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int LOCK_MAX     = DEF_LOCK_MAX
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int STARVE_W = cnt_width(STARVE_LIMIT);
  localparam int LOCK_W   = cnt_width(LOCK_MAX);

  own_e                  state_q, state_d;
  logic                  cpu_active, own_dbg, dbg_gnt, dbg_stay, rd_cap;
  logic                  starve_inc, starve_clr, starve_at_limit;
  logic                  lock_clr, lock_at_limit;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;
  logic                  write_mux, read_mux;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;

  assign cpu_active = bus.cpu_mem_read | bus.cpu_mem_write;
  assign own_dbg    = (state_q == OWN_DBG);
  // Reset abandons any burst immediately, so no grant in a reset cycle.
  assign dbg_gnt    = ~reset & own_dbg & bus.dbg_req;
  assign dbg_stay   = dbg_gnt & bus.dbg_lock & ~lock_at_limit;
  assign rd_cap     = dbg_gnt & ~bus.dbg_we;

  // Starvation: count CPU wins while DBG waits; forget when DBG drops or wins.
  assign starve_inc = ~own_dbg & bus.dbg_req & cpu_active;
  assign starve_clr = own_dbg | ~bus.dbg_req;
  // Burst length: one count per granted cycle, cleared when the burst ends.
  assign lock_clr   = ~dbg_stay;

  sat_counter #(.WIDTH(STARVE_W), .LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk      (clk),
    .rst      (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit)
  );

  sat_counter #(.WIDTH(LOCK_W), .LIMIT(LOCK_MAX)) u_lock_cnt (
    .clk      (clk),
    .rst      (reset),
    .inc      (dbg_gnt),
    .clr      (lock_clr),
    .at_limit (lock_at_limit)
  );

  // Ownership decision for the next cycle.
  always_comb begin
    state_d = state_q;
    if (own_dbg)
      state_d = dbg_stay ? OWN_DBG : OWN_CPU;
    else if (bus.dbg_req && (!cpu_active || starve_at_limit))
      state_d = OWN_DBG;
    else
      state_d = OWN_CPU;
  end

  // Ownership FSM register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= OWN_CPU;
    else       state_q <= state_d;
  end

  // Memory port steering; strobes are suppressed while reset is high.
  always_comb begin
    addr_mux  = bus.cpu_addr;
    wdata_mux = bus.cpu_wdata;
    write_mux = bus.cpu_mem_write;
    read_mux  = bus.cpu_mem_read;
    if (own_dbg) begin
      addr_mux  = bus.dbg_addr;
      wdata_mux = bus.dbg_wdata;
      write_mux = bus.dbg_req & bus.dbg_we;
      read_mux  = bus.dbg_req & ~bus.dbg_we;
    end
    if (reset) begin
      write_mux = 1'b0;
      read_mux  = 1'b0;
    end
  end

  // DBG read capture: data held until the next DBG read, valid pulses once.
  always_comb begin
    dbg_rvalid_d = rd_cap;
    dbg_rdata_d  = rd_cap ? bus.mem_rdata : dbg_rdata_q;
  end

  // DBG read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.mem_write  = write_mux;
  assign bus.mem_read   = read_mux;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = ~reset & own_dbg & cpu_active;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small asynchronous-read memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem [0:255] = '{default: '0};

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  dmem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (DEF_STARVE_LIMIT),
    .LOCK_MAX     (DEF_LOCK_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_mem_read  = 1'b0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.dbg_req       = 1'b0;
    bus.dbg_we        = 1'b0;
    bus.dbg_lock      = 1'b0;
    bus.dbg_addr      = '0;
    bus.dbg_wdata     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1;
    bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'h55AA55AA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write[%0d]: got %b expected 0", i, bus.mem_write); end
      checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt[%0d]: got %b expected 0", i, bus.dbg_gnt); end
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall[%0d]: got %b expected 0", i, bus.cpu_stall); end
    end
    step();
    reset = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== OWN_CPU) begin errors++; $display("FAIL rst_state: got %b expected %b", dut.state_q, OWN_CPU); end
    checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 00000000", bus.dbg_rdata); end
    checks++; if (mem[16] !== 32'h0) begin errors++; $display("FAIL rst_no_write: got %h expected 00000000", mem[16]); end
    step();
  endtask

  task automatic test_dbg_write_read();
    idle_inputs();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1;
    bus.dbg_addr = 32'h10; bus.dbg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL wr_latency: got %b expected 0", bus.dbg_gnt); end
    step(); @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b expected 1", bus.dbg_gnt); end
    checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL wr_mem_write: got %b expected 1", bus.mem_write); end
    checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL wr_mem_addr: got %h expected 00000010", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_wdata: got %h expected deadbeef", bus.mem_wdata); end
    step();
    bus.dbg_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL rd_latency: got %b expected 0", bus.dbg_gnt); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rd_early_read: got %b expected 0", bus.mem_read); end
    step(); @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", bus.dbg_gnt); end
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL rd_mem_read: got %b expected 1", bus.mem_read); end
    step();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dbg_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", bus.dbg_rdata); end
    step(); @(negedge clk);
    checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b expected 0", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata_hold: got %h expected deadbeef", bus.dbg_rdata); end
    step();
  endtask

  task automatic test_starvation();
    idle_inputs();
    bus.cpu_mem_read = 1'b1; bus.cpu_addr = 32'h10;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL starve_gnt[%0d]: got %b expected 0", i, bus.dbg_gnt); end
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_stall[%0d]: got %b expected 0", i, bus.cpu_stall); end
      checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL starve_addr[%0d]: got %h expected 00000010", i, bus.mem_addr); end
      checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_cpu_rdata[%0d]: got %h expected deadbeef", i, bus.cpu_rdata); end
      step();
    end
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL forced_gnt: got %b expected 1", bus.dbg_gnt); end
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL forced_stall: got %b expected 1", bus.cpu_stall); end
    checks++; if (bus.mem_addr !== 32'h20) begin errors++; $display("FAIL forced_addr: got %h expected 00000020", bus.mem_addr); end
    step();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL resume_stall: got %b expected 0", bus.cpu_stall); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL resume_gnt: got %b expected 0", bus.dbg_gnt); end
    checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL resume_addr: got %h expected 00000010", bus.mem_addr); end
    checks++; if (bus.dbg_rvalid !== 1'b1) begin errors++; $display("FAIL forced_rvalid: got %b expected 1", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL forced_rdata: got %h expected 00000000", bus.dbg_rdata); end
    step();
  endtask

  task automatic test_lock_burst();
    logic exp;
    idle_inputs();
    bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1; bus.dbg_we = 1'b1;
    bus.dbg_addr = 32'h40; bus.dbg_wdata = 32'hCAFE0000;
    for (int i = 0; i < 12; i++) begin
      exp = ((i >= 1) && (i <= 8)) || (i >= 10);
      @(negedge clk);
      checks++; if (bus.dbg_gnt !== exp) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, bus.dbg_gnt, exp); end
      checks++; if (bus.mem_write !== exp) begin errors++; $display("FAIL lock_write[%0d]: got %b expected %b", i, bus.mem_write, exp); end
      step();
    end
    bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== OWN_DBG) begin errors++; $display("FAIL viol_state_in: got %b expected %b", dut.state_q, OWN_DBG); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL viol_gnt: got %b expected 0", bus.dbg_gnt); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL viol_write: got %b expected 0", bus.mem_write); end
    step(); @(negedge clk);
    checks++; if (dut.state_q !== OWN_CPU) begin errors++; $display("FAIL viol_state_out: got %b expected %b", dut.state_q, OWN_CPU); end
    step();
  endtask

  task automatic test_cpu_store();
    idle_inputs();
    bus.cpu_mem_write = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL st_write: got %b expected 1", bus.mem_write); end
    checks++; if (bus.mem_addr !== 32'h20) begin errors++; $display("FAIL st_addr: got %h expected 00000020", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL st_wdata: got %h expected 12345678", bus.mem_wdata); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL st_stall: got %b expected 0", bus.cpu_stall); end
    step();
    bus.cpu_mem_write = 1'b0; bus.cpu_mem_read = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL ld_read: got %b expected 1", bus.mem_read); end
    checks++; if (bus.cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL ld_rdata: got %h expected 12345678", bus.cpu_rdata); end
    step();
    bus.cpu_mem_read = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL st_dbg_latency: got %b expected 0", bus.dbg_gnt); end
    step(); @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL st_dbg_gnt: got %b expected 1", bus.dbg_gnt); end
    step();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dbg_rvalid !== 1'b1) begin errors++; $display("FAIL st_dbg_rvalid: got %b expected 1", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'h12345678) begin errors++; $display("FAIL st_dbg_rdata: got %h expected 12345678", bus.dbg_rdata); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    idle_inputs();
    bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1; bus.dbg_we = 1'b1;
    bus.dbg_addr = 32'h80; bus.dbg_wdata = 32'h11110000;
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL mid_latency: got %b expected 0", bus.dbg_gnt); end
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt[%0d]: got %b expected 1", i, bus.dbg_gnt); end
      step();
    end
    reset = 1'b1;
    bus.dbg_wdata = 32'hBADBAD00;
    @(negedge clk);
    checks++; if (dut.u_lock_cnt.cnt_q !== 4'd3) begin errors++; $display("FAIL mid_lock_cnt: got %0d expected 3", dut.u_lock_cnt.cnt_q); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL mid_rst_write: got %b expected 0", bus.mem_write); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 0", bus.dbg_gnt); end
    step();
    reset = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_q !== OWN_CPU) begin errors++; $display("FAIL mid_state: got %b expected %b", dut.state_q, OWN_CPU); end
    checks++; if (dut.u_lock_cnt.cnt_q !== 4'd0) begin errors++; $display("FAIL mid_lock_clr: got %0d expected 0", dut.u_lock_cnt.cnt_q); end
    checks++; if (dut.u_starve_cnt.cnt_q !== 3'd0) begin errors++; $display("FAIL mid_starve_clr: got %0d expected 0", dut.u_starve_cnt.cnt_q); end
    checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 00000000", bus.dbg_rdata); end
    checks++; if (mem[32] !== 32'h11110000) begin errors++; $display("FAIL mid_mem: got %h expected 11110000", mem[32]); end
    step();
  endtask

  initial begin
    test_reset();
    test_dbg_write_read();
    test_starvation();
    test_lock_burst();
    test_cpu_store();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
